flappy_game_engine: RTL and testbench

FLAPPY_GAME_ENGINE -- requirements
Module: flappy_game_engine

---
 rtl/flappy_game_engine_pkg.sv | 37 +++
 rtl/gap_lfsr.sv | 29 ++
 rtl/flappy_game_engine.sv | 204 ++++++++++++++++++++
 tb/tb_flappy_game_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_game_engine_pkg.sv
// Shared geometry, reset positions and state encoding for the flappy game engine.
// The display pipeline imports the same constants so both sides agree on geometry.
package flappy_game_engine_pkg;

    localparam int unsigned ScreenW   = 640;
    localparam int unsigned ScreenH   = 480;
    localparam int unsigned BirdX     = 100;
    localparam int unsigned BirdHalf  = 10;
    localparam int unsigned PipeHalfW = 25;
    localparam int unsigned GapHalf   = 60;
    localparam int unsigned PipeSpeed = 2;
    localparam int unsigned Gravity   = 1;
    localparam int unsigned FlapVel   = 6;
    localparam int unsigned MaxFall   = 8;
    localparam int unsigned PipeYBase = 112;

    localparam logic [10:0] ResetBirdY  = 11'd240;
    localparam logic [10:0] ResetPipe1X = 11'd400;
    localparam logic [10:0] ResetPipe1Y = 11'd200;
    localparam logic [10:0] ResetPipe2X = 11'd720;
    localparam logic [10:0] ResetPipe2Y = 11'd280;
    localparam logic [7:0]  LfsrSeed    = 8'hA5;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StDead
    } state_e;

    // Add up to two crossings to the score, pinning at 255.
    function automatic logic [7:0] sat_add_u8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/gap_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to pick pipe gap heights.
// Advances every clock; the all-zero lock-up state is forced back to the seed.
module gap_lfsr #(
    parameter logic [7:0] Seed = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q, lfsr_d;
    logic       fb;

    always_comb begin
        fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_d = (lfsr_q == 8'h00) ? Seed : {lfsr_q[6:0], fb};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= Seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/flappy_game_engine.sv
// Flappy-bird game engine: IDLE/PLAY/DEAD sequencing, bird physics, two scrolling pipes,
// score and collision, all updated once per frame_tick while playing.
module flappy_game_engine
    import flappy_game_engine_pkg::*;
#(
    parameter int unsigned BIRD_X      = BirdX,
    parameter int unsigned BIRD_HALF   = BirdHalf,
    parameter int unsigned PIPE_HALF_W = PipeHalfW,
    parameter int unsigned GAP_HALF    = GapHalf,
    parameter int unsigned PIPE_SPEED  = PipeSpeed,
    parameter int unsigned GRAVITY     = Gravity,
    parameter int unsigned FLAP_VEL    = FlapVel,
    parameter int unsigned MAX_FALL    = MaxFall,
    parameter int unsigned SCREEN_W    = ScreenW,
    parameter int unsigned SCREEN_H    = ScreenH
) (
    input  logic        dclk,
    input  logic        clr_n,
    input  logic        frame_tick,
    input  logic        flap,
    output logic [10:0] bird_y,
    output logic [10:0] pipe1_x,
    output logic [10:0] pipe2_x,
    output logic [10:0] pipe1_y,
    output logic [10:0] pipe2_y,
    output logic        game_over,
    output logic [7:0]  score
);

    localparam logic [10:0] BirdXU     = 11'(BIRD_X);
    localparam logic [10:0] FloorU     = 11'(BIRD_HALF);
    localparam logic [10:0] PipeWrapAt = 11'(PIPE_HALF_W);
    localparam logic [10:0] PipeWrapX  = 11'(SCREEN_W + PIPE_HALF_W);
    localparam logic [10:0] PipeStep   = 11'(PIPE_SPEED);
    localparam logic [10:0] PipeYBaseU = 11'(PipeYBase);

    localparam logic signed [7:0]  GravS    = 8'(GRAVITY);
    localparam logic signed [7:0]  MaxFallS = 8'(MAX_FALL);
    localparam logic signed [7:0]  FlapVelS = 8'(FLAP_VEL);
    localparam logic signed [11:0] CeilS    = 12'(SCREEN_H - BIRD_HALF);
    localparam logic signed [11:0] FloorS   = 12'(BIRD_HALF);

    localparam logic signed [12:0] BirdXS    = 13'(BIRD_X);
    localparam logic signed [12:0] BirdHalfS = 13'(BIRD_HALF);
    localparam logic signed [12:0] GapHalfS  = 13'(GAP_HALF);
    localparam logic signed [12:0] HitWS     = 13'(PIPE_HALF_W + BIRD_HALF);

    state_e            state_q, state_d;
    logic [10:0]       bird_y_q, bird_y_d;
    logic signed [7:0] vel_q, vel_d;
    logic              pend_q, pend_d;
    logic [1:0][10:0]  pipe_x_q, pipe_x_d;
    logic [1:0][10:0]  pipe_y_q, pipe_y_d;
    logic [7:0]        score_q, score_d;
    logic              game_over_q, game_over_d;

    logic [7:0]         lfsr;
    logic signed [7:0]  vel_dec, vel_fall, vel_new, vel_tick;
    logic signed [11:0] y_sum;
    logic [10:0]        bird_y_tick;
    logic [1:0][10:0]   pipe_x_tick, pipe_y_tick;
    logic [1:0]         crossed;
    logic [1:0]         n_crossed;
    logic               collision;

    gap_lfsr #(
        .Seed (LfsrSeed)
    ) u_gap_lfsr (
        .clk_i  (dclk),
        .rst_ni (clr_n),
        .lfsr_o (lfsr)
    );

    // Overlap test between the bird box and one pipe, outside the gap.
    function automatic logic pipe_hit(input logic [10:0] px, input logic [10:0] py,
                                      input logic [10:0] by);
        logic signed [12:0] dx, adx, bird_lo, bird_hi, gap_lo, gap_hi;
        dx      = $signed({2'b00, px}) - BirdXS;
        adx     = dx[12] ? -dx : dx;
        bird_lo = $signed({2'b00, by}) - BirdHalfS;
        bird_hi = $signed({2'b00, by}) + BirdHalfS;
        gap_lo  = $signed({2'b00, py}) - GapHalfS;
        gap_hi  = $signed({2'b00, py}) + GapHalfS;
        return (adx < HitWS) && ((bird_lo < gap_lo) || (bird_hi > gap_hi));
    endfunction

    assign collision = (bird_y_q <= FloorU)
                     | pipe_hit(pipe_x_q[0], pipe_y_q[0], bird_y_q)
                     | pipe_hit(pipe_x_q[1], pipe_y_q[1], bird_y_q);

    always_comb begin
        vel_dec     = vel_q - GravS;
        vel_fall    = (vel_dec < -MaxFallS) ? -MaxFallS : vel_dec;
        vel_new     = (pend_q || flap) ? FlapVelS : vel_fall;
        y_sum       = $signed({1'b0, bird_y_q}) + $signed({{4{vel_new[7]}}, vel_new});
        bird_y_tick = y_sum[10:0];
        vel_tick    = vel_new;
        if (y_sum > CeilS) begin
            bird_y_tick = CeilS[10:0];
            vel_tick    = '0;
        end else if (y_sum <= FloorS) begin
            // Velocity is kept; the floor contact itself raises the collision next cycle.
            bird_y_tick = FloorS[10:0];
        end
    end

    always_comb begin
        pipe_x_tick = pipe_x_q;
        pipe_y_tick = pipe_y_q;
        crossed     = '0;
        for (int i = 0; i < 2; i++) begin
            if (pipe_x_q[i] <= PipeWrapAt) begin
                pipe_x_tick[i] = PipeWrapX;
                pipe_y_tick[i] = PipeYBaseU + {3'b000, lfsr};
            end else begin
                pipe_x_tick[i] = pipe_x_q[i] - PipeStep;
                crossed[i]     = (pipe_x_q[i] >= BirdXU) && (pipe_x_tick[i] < BirdXU);
            end
        end
        n_crossed = {1'b0, crossed[0]} + {1'b0, crossed[1]};
    end

    always_comb begin
        state_d     = state_q;
        bird_y_d    = bird_y_q;
        vel_d       = vel_q;
        pend_d      = pend_q;
        pipe_x_d    = pipe_x_q;
        pipe_y_d    = pipe_y_q;
        score_d     = score_q;
        game_over_d = game_over_q;
        unique case (state_q)
            StIdle: begin
                if (flap) begin
                    state_d = StPlay;
                    vel_d   = FlapVelS;
                    pend_d  = 1'b0;
                end
            end
            StPlay: begin
                if (collision) begin
                    state_d     = StDead;
                    game_over_d = 1'b1;
                end else if (frame_tick) begin
                    bird_y_d = bird_y_tick;
                    vel_d    = vel_tick;
                    pend_d   = 1'b0;
                    pipe_x_d = pipe_x_tick;
                    pipe_y_d = pipe_y_tick;
                    score_d  = sat_add_u8(score_q, n_crossed);
                end else if (flap) begin
                    pend_d = 1'b1;
                end
            end
            StDead: begin
                if (flap) begin
                    state_d     = StIdle;
                    game_over_d = 1'b0;
                    bird_y_d    = ResetBirdY;
                    vel_d       = '0;
                    pend_d      = 1'b0;
                    pipe_x_d    = {ResetPipe2X, ResetPipe1X};
                    pipe_y_d    = {ResetPipe2Y, ResetPipe1Y};
                    score_d     = '0;
                end
            end
            default: begin
                state_d     = StIdle;
                game_over_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= StIdle;
            bird_y_q    <= ResetBirdY;
            vel_q       <= '0;
            pend_q      <= 1'b0;
            pipe_x_q    <= {ResetPipe2X, ResetPipe1X};
            pipe_y_q    <= {ResetPipe2Y, ResetPipe1Y};
            score_q     <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bird_y_q    <= bird_y_d;
            vel_q       <= vel_d;
            pend_q      <= pend_d;
            pipe_x_q    <= pipe_x_d;
            pipe_y_q    <= pipe_y_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
        end
    end

    assign bird_y    = bird_y_q;
    assign pipe1_x   = pipe_x_q[0];
    assign pipe2_x   = pipe_x_q[1];
    assign pipe1_y   = pipe_y_q[0];
    assign pipe2_y   = pipe_y_q[1];
    assign game_over = game_over_q;
    assign score     = score_q;

endmodule

// File: tb/tb_flappy_game_engine.sv
// Directed bench for flappy_game_engine: reset, start, flap timing, floor death,
// pipe pass/wrap with scoring, and both ways out of DEAD.
module tb_flappy_game_engine;

    logic        dclk = 1'b0;
    logic        clr_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic        flap = 1'b0;
    logic [10:0] bird_y, pipe1_x, pipe2_x, pipe1_y, pipe2_y;
    logic        game_over;
    logic [7:0]  score;

    int n_cmp = 0;
    int n_bad = 0;

    flappy_game_engine dut (
        .dclk       (dclk),
        .clr_n      (clr_n),
        .frame_tick (frame_tick),
        .flap       (flap),
        .bird_y     (bird_y),
        .pipe1_x    (pipe1_x),
        .pipe2_x    (pipe2_x),
        .pipe1_y    (pipe1_y),
        .pipe2_y    (pipe2_y),
        .game_over  (game_over),
        .score      (score)
    );

    always #20 dclk = ~dclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge dclk);
        clr_n = 1'b0;
        #5;
        @(negedge dclk);
        clr_n = 1'b1;
    endtask

    task automatic do_tick(input logic f);
        @(negedge dclk);
        frame_tick = 1'b1;
        flap       = f;
        @(posedge dclk);
        #1;
        frame_tick = 1'b0;
        flap       = 1'b0;
    endtask

    task automatic do_flap();
        @(negedge dclk);
        flap = 1'b1;
        @(posedge dclk);
        #1;
        flap = 1'b0;
    endtask

    task automatic test_reset();
        #5;
        clr_n = 1'b0;
        #5;
        n_cmp++; if (bird_y !== 11'd240) begin n_bad++;
            $display("FAIL reset_bird_y: got %0d want 240", bird_y); end
        n_cmp++; if (pipe1_x !== 11'd400) begin n_bad++;
            $display("FAIL reset_pipe1_x: got %0d want 400", pipe1_x); end
        n_cmp++; if (pipe1_y !== 11'd200) begin n_bad++;
            $display("FAIL reset_pipe1_y: got %0d want 200", pipe1_y); end
        n_cmp++; if (pipe2_x !== 11'd720) begin n_bad++;
            $display("FAIL reset_pipe2_x: got %0d want 720", pipe2_x); end
        n_cmp++; if (pipe2_y !== 11'd280) begin n_bad++;
            $display("FAIL reset_pipe2_y: got %0d want 280", pipe2_y); end
        n_cmp++; if (score !== 8'd0) begin n_bad++;
            $display("FAIL reset_score: got %0d want 0", score); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++;
            $display("FAIL reset_game_over: got %0b want 0", game_over); end
        @(negedge dclk);
        clr_n = 1'b1;
        for (int i = 0; i < 10; i++) do_tick(1'b0);
        n_cmp++; if (bird_y !== 11'd240) begin n_bad++;
            $display("FAIL idle_ticks_bird_y: got %0d want 240", bird_y); end
        n_cmp++; if (pipe1_x !== 11'd400 || pipe2_x !== 11'd720) begin n_bad++;
            $display("FAIL idle_ticks_pipes_x: got %0d/%0d want 400/720", pipe1_x, pipe2_x); end
        n_cmp++; if (game_over !== 1'b0 || score !== 8'd0) begin n_bad++;
            $display("FAIL idle_ticks_status: got go=%0b score=%0d want 0/0", game_over, score); end
    endtask

    task automatic test_start();
        do_flap();
        n_cmp++; if (bird_y !== 11'd240 || pipe1_x !== 11'd400) begin n_bad++;
            $display("FAIL start_positions: got %0d/%0d want 240/400", bird_y, pipe1_x); end
        do_tick(1'b0);
        n_cmp++; if (bird_y !== 11'd245) begin n_bad++;
            $display("FAIL start_tick1_bird_y: got %0d want 245", bird_y); end
        n_cmp++; if (pipe1_x !== 11'd398) begin n_bad++;
            $display("FAIL start_tick1_pipe1_x: got %0d want 398", pipe1_x); end
        do_tick(1'b0);
        n_cmp++; if (bird_y !== 11'd249) begin n_bad++;
            $display("FAIL start_tick2_bird_y: got %0d want 249", bird_y); end
    endtask

    task automatic test_flap_timing();
        do_tick(1'b1);
        n_cmp++; if (bird_y !== 11'd255) begin n_bad++;
            $display("FAIL coincident_flap_bird_y: got %0d want 255", bird_y); end
        do_flap();
        n_cmp++; if (bird_y !== 11'd255) begin n_bad++;
            $display("FAIL pending_no_move: got %0d want 255", bird_y); end
        do_tick(1'b0);
        n_cmp++; if (bird_y !== 11'd261) begin n_bad++;
            $display("FAIL pending_flap_bird_y: got %0d want 261", bird_y); end
        do_tick(1'b0);
        n_cmp++; if (bird_y !== 11'd266) begin n_bad++;
            $display("FAIL pending_cleared_bird_y: got %0d want 266", bird_y); end
    endtask

    task automatic test_floor_death();
        apply_reset();
        do_flap();
        for (int t = 1; t <= 41; t++) begin
            do_tick(1'b0);
            if (t == 15) begin
                n_cmp++; if (bird_y !== 11'd211) begin n_bad++;
                    $display("FAIL fall_tick15_bird_y: got %0d want 211", bird_y); end
            end
            if (t == 16) begin
                n_cmp++; if (bird_y !== 11'd203) begin n_bad++;
                    $display("FAIL fall_tick16_bird_y: got %0d want 203", bird_y); end
            end
            if (t == 40) begin
                n_cmp++; if (bird_y !== 11'd11 || game_over !== 1'b0) begin n_bad++;
                    $display("FAIL fall_tick40: got y=%0d go=%0b want 11/0", bird_y, game_over); end
            end
        end
        n_cmp++; if (bird_y !== 11'd10) begin n_bad++;
            $display("FAIL floor_clamp_bird_y: got %0d want 10", bird_y); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++;
            $display("FAIL floor_game_over_early: got %0b want 0", game_over); end
        @(posedge dclk);
        #1;
        n_cmp++; if (game_over !== 1'b1) begin n_bad++;
            $display("FAIL floor_game_over_rise: got %0b want 1", game_over); end
        for (int i = 0; i < 3; i++) do_tick(1'b0);
        n_cmp++; if (bird_y !== 11'd10 || pipe1_x !== 11'd318) begin n_bad++;
            $display("FAIL dead_frozen: got y=%0d p1x=%0d want 10/318", bird_y, pipe1_x); end
    endtask

    task automatic test_reset_in_dead();
        @(negedge dclk);
        clr_n = 1'b0;
        #1;
        n_cmp++; if (game_over !== 1'b0 || bird_y !== 11'd240 || pipe1_x !== 11'd400) begin
            n_bad++;
            $display("FAIL dead_reset_async: got go=%0b y=%0d p1x=%0d want 0/240/400",
                     game_over, bird_y, pipe1_x);
        end
        @(negedge dclk);
        clr_n = 1'b1;
        do_tick(1'b0);
        n_cmp++; if (bird_y !== 11'd240 || pipe1_x !== 11'd400) begin n_bad++;
            $display("FAIL dead_reset_idle: got y=%0d p1x=%0d want 240/400", bird_y, pipe1_x); end
    endtask

    task automatic test_pipe_pass();
        do_flap();
        for (int t = 1; t <= 189; t++) begin
            do_tick(bird_y < 11'd200);
            if (t == 150) begin
                n_cmp++; if (pipe1_x !== 11'd100 || score !== 8'd0) begin n_bad++;
                    $display("FAIL pipe_tick150: got p1x=%0d score=%0d want 100/0", pipe1_x, score);
                end
            end
            if (t == 151) begin
                n_cmp++; if (pipe1_x !== 11'd98 || score !== 8'd1) begin n_bad++;
                    $display("FAIL pipe_tick151: got p1x=%0d score=%0d want 98/1", pipe1_x, score);
                end
            end
            if (t == 188) begin
                n_cmp++; if (pipe1_x !== 11'd24) begin n_bad++;
                    $display("FAIL pipe_tick188_pipe1_x: got %0d want 24", pipe1_x); end
            end
        end
        n_cmp++; if (pipe1_x !== 11'd665) begin n_bad++;
            $display("FAIL pipe_wrap_x: got %0d want 665", pipe1_x); end
        n_cmp++; if (pipe1_y < 11'd112 || pipe1_y > 11'd367) begin n_bad++;
            $display("FAIL pipe_wrap_y: got %0d want 112..367", pipe1_y); end
        n_cmp++; if (pipe2_x !== 11'd342 || game_over !== 1'b0 || score !== 8'd1) begin n_bad++;
            $display("FAIL pipe_tick189_state: got p2x=%0d go=%0b score=%0d want 342/0/1",
                     pipe2_x, game_over, score);
        end
    endtask

    task automatic test_dead_flap();
        for (int i = 0; i < 150 && game_over !== 1'b1; i++) do_tick(1'b0);
        n_cmp++; if (game_over !== 1'b1) begin n_bad++;
            $display("FAIL dead_reached: got %0b want 1 within 150 ticks", game_over); end
        n_cmp++; if (score !== 8'd1) begin n_bad++;
            $display("FAIL dead_score_frozen: got %0d want 1", score); end
        do_flap();
        n_cmp++; if (game_over !== 1'b0 || score !== 8'd0) begin n_bad++;
            $display("FAIL dead_flap_status: got go=%0b score=%0d want 0/0", game_over, score); end
        n_cmp++; if (bird_y !== 11'd240 || pipe1_x !== 11'd400 || pipe1_y !== 11'd200 ||
                     pipe2_x !== 11'd720 || pipe2_y !== 11'd280) begin
            n_bad++;
            $display("FAIL dead_flap_positions: got %0d/%0d/%0d/%0d/%0d want 240/400/200/720/280",
                     bird_y, pipe1_x, pipe1_y, pipe2_x, pipe2_y);
        end
        do_tick(1'b0);
        n_cmp++; if (bird_y !== 11'd240) begin n_bad++;
            $display("FAIL dead_flap_idle_tick: got %0d want 240", bird_y); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_flap_timing();
        test_floor_death();
        test_reset_in_dead();
        test_pipe_pass();
        test_dead_flap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
